// File: rtl/pipeline_stall_controller_if.sv
// Pipeline-control bundle between the hazard/branch/memory stages and the
// stall controller.
//   master : pipeline side, drives the hazard/branch/SRAM status, reads controls
//   slave  : stall controller, reads status, drives freeze/flush controls and stats
// Signals:
//   hazard_detected, branch_taken, mem_req, sram_ready : stage status inputs
//   freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back : controls
//   mem_timeout : sticky SRAM watchdog fault
//   stall_count, flush_count : saturating statistics, CNT_W bits
interface pipeline_stall_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic             hazard_detected;
    logic             branch_taken;
    logic             mem_req;
    logic             sram_ready;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             bubble_id_exe;
    logic             flush_if_id;
    logic             freeze_back;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output hazard_detected, branch_taken, mem_req, sram_ready,
        input  freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back,
        input  mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  hazard_detected, branch_taken, mem_req, sram_ready,
        output freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back,
        output mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for a 5-stage pipeline.
// Merges the ID data-hazard flag, the EXE taken-branch flag and the MEM SRAM
// handshake into per-register freeze/flush controls, watches SRAM waits with a
// watchdog (sticky fault after TIMEOUT wait cycles) and keeps saturating
// stall/flush statistics.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   ctl  : pipeline_stall_controller_if.slave (status in, controls/stats out)
// Controls are combinational from state and inputs; stats and mem_timeout are
// registered.
module pipeline_stall_controller #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input logic                        clk,
    input logic                        rst,
    pipeline_stall_controller_if.slave ctl
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    localparam logic [WaitW-1:0] WaitOne = {{(WaitW-1){1'b0}}, 1'b1};
    localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFault   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic mem_stall;
    logic freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back;

    // A pending SRAM access only stalls while the watchdog has not tripped.
    assign mem_stall = ctl.mem_req & ~ctl.sram_ready & (state_q != StFault);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            timeout_q     <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_q     <= timeout_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    state_d    = StMemWait;
                    wait_cnt_d = WaitOne;
                end
            end
            StMemWait: begin
                if (!mem_stall) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitMax) begin
                    state_d   = StFault;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitOne;
                end
            end
            StFault: begin
                // Absorbing until reset.
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Control outputs, priority: fault > memory stall > branch flush > hazard
    always_comb begin
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        bubble_id_exe = 1'b0;
        flush_if_id   = 1'b0;
        freeze_back   = 1'b0;
        if (rst) begin
            // All controls held low while in reset.
        end else if (state_q == StFault || mem_stall) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            freeze_back  = 1'b1;
        end else if (ctl.branch_taken) begin
            // PC loads the branch target; the ID instruction is squashed.
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
        end else if (ctl.hazard_detected) begin
            freeze_pc     = 1'b1;
            freeze_if_id  = 1'b1;
            bubble_id_exe = 1'b1;
        end
    end

    // Saturating statistics
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if ((freeze_pc | freeze_back) && stall_count_q != CntMax) begin
            stall_count_d = stall_count_q + CntOne;
        end
        if (flush_if_id && flush_count_q != CntMax) begin
            flush_count_d = flush_count_q + CntOne;
        end
    end

    assign ctl.freeze_pc     = freeze_pc;
    assign ctl.freeze_if_id  = freeze_if_id;
    assign ctl.bubble_id_exe = bubble_id_exe;
    assign ctl.flush_if_id   = flush_if_id;
    assign ctl.freeze_back   = freeze_back;
    assign ctl.mem_timeout   = timeout_q;
    assign ctl.stall_count   = stall_count_q;
    assign ctl.flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: the driver applies one input
// vector per cycle, predicts the response with a behavioural model and queues
// it; a monitor pops and compares on the falling edge.
module tb_pipeline_stall_controller;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          CntMax  = (1 << CNT_W) - 1;

    typedef struct {
        logic [4:0]       ctrl; // {freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back}
        logic             to;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    // Model state: fault latched, length of the current run of stalled memory
    // cycles, and the two statistics.
    bit m_fault;
    int m_run;
    int m_stall;
    int m_flush;

    pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_controller #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctl(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and queue the predicted response.
    task automatic step(input bit hz, input bit br, input bit mr, input bit sr, input bit rs);
        exp_t e;
        bit   stalled;
        @(posedge clk);
        #1;
        bus.hazard_detected = hz;
        bus.branch_taken    = br;
        bus.mem_req         = mr;
        bus.sram_ready      = sr;
        rst                 = rs;

        e.to = m_fault;
        e.sc = CNT_W'(m_stall);
        e.fc = CNT_W'(m_flush);
        stalled = !m_fault && mr && !sr;
        if (rs)                   e.ctrl = 5'b00000;
        else if (m_fault)         e.ctrl = 5'b11001;
        else if (stalled)         e.ctrl = 5'b11001;
        else if (br)              e.ctrl = 5'b00110;
        else if (hz)              e.ctrl = 5'b11100;
        else                      e.ctrl = 5'b00000;
        sb_q.push_back(e);

        if (rs) begin
            m_fault = 0;
            m_run   = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if ((e.ctrl[4] || e.ctrl[0]) && m_stall < CntMax) m_stall++;
            if (e.ctrl[1] && m_flush < CntMax) m_flush++;
            if (!m_fault) begin
                // The watchdog trips on the stalled cycle after TIMEOUT waits.
                m_run = stalled ? m_run + 1 : 0;
                if (m_run == TIMEOUT + 1) m_fault = 1;
            end
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ctrl", 32'({bus.freeze_pc, bus.freeze_if_id, bus.bubble_id_exe,
                                 bus.flush_if_id, bus.freeze_back}), 32'(e.ctrl));
                chk("mem_timeout", 32'(bus.mem_timeout), 32'(e.to));
                chk("stall_count", 32'(bus.stall_count), 32'(e.sc));
                chk("flush_count", 32'(bus.flush_count), 32'(e.fc));
            end
        end
    end

    // Hard time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        checks = 0;
        errors = 0;
        m_fault = 0;
        m_run = 0;
        m_stall = 0;
        m_flush = 0;
        rst = 1'b1;
        bus.hazard_detected = 1'b0;
        bus.branch_taken    = 1'b0;
        bus.mem_req         = 1'b0;
        bus.sram_ready      = 1'b0;

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Hazard only, two cycles
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Branch over hazard
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Three-cycle SRAM wait then release
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Branch held through a memory stall, applied on release
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Zero-wait access
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Watchdog timeout, fault absorbs everything, then reset
        step(0, 0, 0, 0, 1);
        repeat (8) step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Stall counter saturation
        step(0, 0, 0, 0, 1);
        repeat (20) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Flush counter saturation
        step(0, 0, 0, 0, 1);
        repeat (18) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Randomized traffic; bursts with long SRAM waits reach the watchdog
        for (int i = 0; i < 600; i++) begin
            bit mr;
            bit sr;
            mr = ($urandom_range(0, 3) != 0);
            sr = ($urandom_range(0, 4) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), mr, sr,
                 ($urandom_range(0, 59) == 0));
        end
        step(0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Combines three inputs into per-register freeze/flush controls for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB:
  - the ID-stage data-hazard flag;
  - the EXE-stage branch-taken flag;
  - the MEM-stage SRAM handshake.
- Tracks multi-cycle SRAM waits with a watchdog. Keeps saturating stall and flush statistics.

Parameters:
- TIMEOUT, 64, max consecutive SRAM wait cycles before fault (≥2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hazard_detected  in  1  RAW hazard on the instruction in ID.
- branch_taken  in  1  EXE stage resolves a taken branch this cycle.
- mem_req  in  1  MEM stage holds a load/store needing SRAM.
- sram_ready  in  1  SRAM completes the MEM-stage access this cycle.
- freeze_pc  out  1  hold PC.
- freeze_if_id  out  1  hold IF/ID register.
- bubble_id_exe  out  1  load NOP controls into ID/EXE.
- flush_if_id  out  1  clear IF/ID to NOP.
- freeze_back  out  1  hold ID/EXE, EXE/MEM, MEM/WB; suppress WB enable.
- mem_timeout  out  1  sticky fault flag.
- stall_count  out  CNT_W  cycles with any freeze active, saturating.
- flush_count  out  CNT_W  taken-branch flushes applied, saturating.

Behaviour:
- States: RUN, MEM_WAIT, FAULT (2-bit register).
- Control outputs are combinational from state and inputs (same-cycle effect). Counters and mem_timeout are registered.
- Reset (rst=1 at posedge):
  - state=RUN, wait_cnt=0, stall_count=0, flush_count=0, mem_timeout=0.
  - While rst=1, all five control outputs are forced 0.
- Priority, highest first: FAULT > memory stall > branch flush > hazard.
- Memory stall: mem_stall = mem_req & ~sram_ready, in RUN or MEM_WAIT.
  - Forces freeze_pc=freeze_if_id=freeze_back=1 and bubble_id_exe=flush_if_id=0.
  - branch_taken and hazard_detected are ignored that cycle. EXE is frozen, so branch_taken persists and is applied on the release cycle.
- Branch, when there is no mem_stall and state≠FAULT:
  - branch_taken=1 → flush_if_id=1, bubble_id_exe=1, freeze_pc=0 (PC loads target), freeze_if_id=0.
  - hazard_detected is ignored, since the ID instruction is being flushed.
- Hazard, when there is no mem_stall, no branch, and state≠FAULT:
  - hazard_detected=1 → freeze_pc=1, freeze_if_id=1, bubble_id_exe=1.
- Otherwise all control outputs are 0.
- Transitions:
  - RUN → MEM_WAIT when mem_stall; wait_cnt←1.
  - MEM_WAIT stays while mem_stall and wait_cnt<TIMEOUT; wait_cnt increments.
  - MEM_WAIT → RUN when sram_ready=1 or mem_req=0 (release cycle: mem freeze drops the same cycle); wait_cnt←0.
  - MEM_WAIT → FAULT when mem_stall and wait_cnt==TIMEOUT; mem_timeout←1.
  - FAULT is absorbing until rst. In FAULT: freeze_pc=freeze_if_id=freeze_back=1, others 0.
- Zero-wait access (mem_req & sram_ready in RUN): no stall, state stays RUN.
- stall_count increments on every cycle where freeze_pc|freeze_back=1, including FAULT cycles. It saturates at 2^CNT_W−1.
- flush_count increments on each cycle flush_if_id=1 and saturates at 2^CNT_W−1.
- Reset mid-MEM_WAIT or in FAULT returns to RUN next cycle and clears mem_timeout and the counters.

Test Plan:
- Hazard only: hazard_detected=1 for 2 cycles, no mem_req → freeze_pc=freeze_if_id=bubble_id_exe=1 both cycles; stall_count=2; flush_count=0.
- Branch over hazard: branch_taken=1 with hazard_detected=1 → flush_if_id=1, bubble_id_exe=1, freeze_pc=0; flush_count=1.
- SRAM wait: mem_req=1, sram_ready=0 for 3 cycles, then 1 → freeze_back=1 for exactly 3 cycles; state MEM_WAIT→RUN on cycle 4 with no freeze; stall_count=3.
- Branch during mem stall: branch_taken=1 throughout the 3-cycle wait → flush_if_id=0 during wait, flush_if_id=1 on the release cycle; flush_count=1.
- Timeout (TIMEOUT=4): mem_req=1, sram_ready=0 held → mem_timeout=1 after the 5th stalled cycle, FAULT freezes persist. Then rst=1 for 1 cycle → all outputs 0, state RUN.
- Saturation (CNT_W=4): hazard held 20 cycles → stall_count stops at 15.
